// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit queue: default sizing constants and
// the launch-sequencer state type.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Default byte capacity of the transmit queue (power of two, 4..256).
   localparam int unsigned UART_DEPTH_DEFAULT = 16;

   // Default number of clk cycles, counted from the launch cycle, that the
   // queue waits for the transmitter to report busy before giving up.
   localparam int unsigned UART_START_TIMEOUT_DEFAULT = 4;

   // Launch sequencer states.
   typedef enum logic [1:0] {
      TXQ_IDLE       = 2'd0,  // waiting for a byte and an idle transmitter
      TXQ_LAUNCH     = 2'd1,  // one-cycle transmit pulse
      TXQ_WAIT_START = 2'd2,  // waiting for tx_busy to rise
      TXQ_WAIT_DONE  = 2'd3   // frame in progress, waiting for tx_busy to fall
   } tx_q_state_t;

endpackage : uart_pkg

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous single-clock FIFO with occupancy count. Writes while full and
// reads while empty are ignored. Head data is presented combinationally.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (pointers and count only)
//   push_i   in   write request
//   wdata_i  in   write data
//   pop_i    in   read request (advances the head)
//   rdata_o  out  current head entry
//   count_o  out  number of stored entries
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
// -----------------------------------------------------------------------------
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // NOTE: every signal assigned in always_comb gets a default first so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage array has no reset; its contents are unreachable until
   // written because pointers and count are reset, and leaving it unreset lets
   // it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : uart_fifo

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
// Byte queue placed in front of a UART transmitter. Bytes written on wr_data
// are buffered and handed to the transmitter one at a time: a byte is popped
// into a holding register, a one-cycle transmit pulse is issued, and the queue
// then follows tx_busy through the frame before launching the next byte.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   wr_data    in   byte to enqueue
//   wr_en      in   enqueue request (one byte per cycle)
//   full       out  queue holds DEPTH bytes
//   empty      out  queue holds no bytes
//   count      out  current occupancy
//   overflow   out  sticky: a write arrived while full and was dropped
//   start_err  out  sticky: tx_busy did not rise within START_TIMEOUT cycles
//   data_in    out  byte presented to the transmitter
//   transmit   out  one-cycle launch pulse to the transmitter
//   tx_busy    in   transmitter busy for the whole frame
// -----------------------------------------------------------------------------
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH         = UART_DEPTH_DEFAULT,
   parameter int unsigned START_TIMEOUT = UART_START_TIMEOUT_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 wr_data,
   input  logic                       wr_en,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       start_err,
   output logic [7:0]                 data_in,
   output logic                       transmit,
   input  logic                       tx_busy
);

   localparam int unsigned TW = $clog2(START_TIMEOUT+1);
   // The launch cycle counts as the first waiting cycle, so the timer starts
   // at 1 on entry to WAIT_START and expires on its START_TIMEOUT-1 value.
   localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);

   tx_q_state_t   state_q, state_d;
   logic [7:0]    data_in_q, data_in_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          overflow_q, overflow_d;
   logic          start_err_q, start_err_d;

   logic          fifo_pop;
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (wr_en),
      .wdata_i (wr_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // A write is dropped whenever the queue is full before the edge, even if
   // the sequencer pops in the same cycle; the FIFO itself enforces the drop.
   assign overflow_d = overflow_q | (wr_en & fifo_full);

   always_comb begin
      state_d     = state_q;
      data_in_d   = data_in_q;
      timer_d     = timer_q;
      start_err_d = start_err_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         TXQ_IDLE: begin
            if (!fifo_empty && !tx_busy) begin
               fifo_pop  = 1'b1;
               data_in_d = fifo_rdata;
               state_d   = TXQ_LAUNCH;
            end
         end
         TXQ_LAUNCH: begin
            timer_d = TW'(1);
            state_d = TXQ_WAIT_START;
         end
         TXQ_WAIT_START: begin
            if (tx_busy) begin
               state_d = TXQ_WAIT_DONE;
            end else if (timer_q >= TIMER_LAST) begin
               // The byte is abandoned; it has already left the queue.
               start_err_d = 1'b1;
               state_d     = TXQ_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         TXQ_WAIT_DONE: begin
            if (!tx_busy) state_d = TXQ_IDLE;
         end
         default: state_d = TXQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= TXQ_IDLE;
         data_in_q   <= 8'h00;
         timer_q     <= '0;
         overflow_q  <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_in_q   <= data_in_d;
         timer_q     <= timer_d;
         overflow_q  <= overflow_d;
         start_err_q <= start_err_d;
      end
   end

   // transmit is decoded from the state register alone, so reset clears it
   // immediately and it can only be high for the single LAUNCH cycle.
   assign transmit  = (state_q == TXQ_LAUNCH);
   assign data_in   = data_in_q;
   assign full      = fifo_full;
   assign empty     = fifo_empty;
   assign overflow  = overflow_q;
   assign start_err = start_err_q;

endmodule : uart_tx_queue

// File: tb/tb_uart_tx_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
// Self-checking bench for uart_tx_queue: table-driven fill/overflow vectors,
// directed multi-cycle sequences, a 9600-baud serial loopback and a randomized
// run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;
   import uart_pkg::*;

   localparam int DEPTH         = UART_DEPTH_DEFAULT;
   localparam int START_TIMEOUT = UART_START_TIMEOUT_DEFAULT;
   localparam int CW            = $clog2(DEPTH+1);
   localparam int CLK_HALF      = 500;   // 1 MHz clock
   localparam int CLKS_PER_BIT  = 104;   // 1 MHz / 9600 baud

   typedef enum int {TX_MANUAL, TX_FAST, TX_SERIAL} tx_mode_t;

   typedef struct {
      logic       wr_en;
      logic [7:0] data;
      int         exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    wr_data;
   logic          wr_en;
   logic          tx_busy;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          start_err;
   logic [7:0]    data_in;
   logic          transmit;

   int checks_total  = 0;
   int checks_passed = 0;

   // Transmitter models and monitors
   tx_mode_t   mode = TX_MANUAL;
   logic [7:0] tx_log[$];
   int         pulse_falls[$];
   int         busy_falls;
   logic       prev_transmit;
   bit         resp_pending;
   int         busy_left;
   logic [7:0] ser_data;
   bit         ser_active;
   logic [9:0] ser_frame;
   int         ser_bit, ser_cnt;
   logic       line;
   bit         rx_active;
   int         rx_cnt, rx_bit;
   logic [7:0] rx_shift;
   logic [7:0] rx_log[$];

   // Reference model
   bit         model_on;
   logic [7:0] model_q[$];
   logic       model_ovf;
   int         stall;

   uart_tx_queue #(
      .DEPTH         (DEPTH),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .start_err (start_err),
      .data_in   (data_in),
      .transmit  (transmit),
      .tx_busy   (tx_busy)
   );

   initial forever #CLK_HALF clk = ~clk;

   initial begin
      #(CLK_HALF * 2 * 60000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"},     count,     0);
      check({tag, "_empty"},     empty,     1);
      check({tag, "_full"},      full,      0);
      check({tag, "_overflow"},  overflow,  0);
      check({tag, "_start_err"}, start_err, 0);
      check({tag, "_transmit"},  transmit,  0);
      check({tag, "_data_in"},   data_in,   8'h00);
   endtask

   task automatic clear_bench_state();
      model_on      = 0;
      model_q.delete();
      model_ovf     = 0;
      stall         = 0;
      tx_log.delete();
      pulse_falls.delete();
      rx_log.delete();
      busy_falls    = 0;
      prev_transmit = 0;
      resp_pending  = 0;
      busy_left     = 0;
      ser_active    = 0;
      line          = 1'b1;
      rx_active     = 0;
   endtask

   // One clock cycle: wait for the edge, sample settled outputs, update the
   // reference model, then let the transmitter model drive tx_busy.
   task automatic cycle();
      int         pre_size;
      logic [7:0] exp_byte;
      @(posedge clk);
      #1;
      if (transmit) begin
         check("no_transmit_while_busy", tx_busy, 0);
         check("transmit_single_cycle", prev_transmit, 0);
         tx_log.push_back(data_in);
         pulse_falls.push_back(busy_falls);
      end
      prev_transmit = transmit;

      if (model_on) begin
         pre_size = model_q.size();
         if (transmit) begin
            check("model_pop_from_nonempty", pre_size > 0, 1);
            if (pre_size > 0) begin
               exp_byte = model_q.pop_front();
               check("model_data_in", data_in, exp_byte);
            end
         end
         if (wr_en) begin
            if (pre_size >= DEPTH) model_ovf = 1'b1;
            else model_q.push_back(wr_data);
         end
         check("model_count",    count,    model_q.size());
         check("model_full",     full,     model_q.size() == DEPTH);
         check("model_empty",    empty,    model_q.size() == 0);
         check("model_overflow", overflow, model_ovf);
      end

      case (mode)
         TX_FAST: begin
            if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0) begin
                  tx_busy = 1'b0;
                  busy_falls++;
               end
            end
            if (resp_pending) begin
               resp_pending = 0;
               tx_busy      = 1'b1;
               busy_left    = $urandom_range(1, 6);
            end
            if (transmit) resp_pending = 1;
         end
         TX_SERIAL: begin
            if (resp_pending) begin
               resp_pending = 0;
               ser_active   = 1;
               ser_frame    = {1'b1, ser_data, 1'b0};
               ser_bit      = 0;
               ser_cnt      = 0;
               tx_busy      = 1'b1;
               line         = ser_frame[0];
            end else if (ser_active) begin
               ser_cnt++;
               if (ser_cnt == CLKS_PER_BIT) begin
                  ser_cnt = 0;
                  ser_bit++;
                  if (ser_bit == 10) begin
                     ser_active = 0;
                     tx_busy    = 1'b0;
                     busy_falls++;
                     line       = 1'b1;
                  end else begin
                     ser_frame = {1'b1, ser_frame[9:1]};
                     line      = ser_frame[0];
                  end
               end
            end
            if (transmit) begin
               resp_pending = 1;
               ser_data     = data_in;
            end
         end
         default: ;
      endcase

      // Serial receiver: centre-samples each bit, LSB first.
      if (!rx_active) begin
         if (line == 1'b0) begin
            rx_active = 1;
            rx_cnt    = 0;
            rx_bit    = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == CLKS_PER_BIT/2 + (rx_bit + 1) * CLKS_PER_BIT) begin
            if (rx_bit < 8) begin
               rx_shift = {line, rx_shift[7:1]};
               rx_bit++;
            end else begin
               check("rx_stop_bit", line, 1);
               rx_log.push_back(rx_shift);
               rx_active = 0;
            end
         end
      end

      if (model_on && mode == TX_FAST) begin
         if (model_q.size() > 0 && !tx_busy && !resp_pending) stall++;
         else stall = 0;
         check("launch_not_stalled", stall <= 4, 1);
      end
   endtask

   task automatic reset_dut();
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_busy = 1'b0;
      mode    = TX_MANUAL;
      repeat (2) @(posedge clk);
      clear_bench_state();
      @(negedge clk);
      rst = 1'b1;
      cycle();
      check("release_no_transmit", transmit, 0);
   endtask

   vec_t vecs[18];

   initial begin
      // ---------------- reset state ----------------
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_busy = 1'b0;
      clear_bench_state();
      #(CLK_HALF * 3);
      check_reset_outputs("por");

      // ---------------- single byte latency ----------------
      reset_dut();
      mode    = TX_FAST;
      wr_data = 8'hA5;
      wr_en   = 1'b1;
      cycle();
      wr_en = 1'b0;
      check("a5_push_edge_transmit", transmit, 0);
      check("a5_push_edge_count", count, 1);
      cycle();
      check("a5_launch_transmit", transmit, 1);
      check("a5_launch_data_in", data_in, 8'hA5);
      check("a5_launch_count", count, 0);
      repeat (12) cycle();
      check("a5_pulse_total", tx_log.size(), 1);
      check("a5_data_in_held", data_in, 8'hA5);
      check("a5_start_err", start_err, 0);

      // ---------------- table: fill to full with tx_busy held ----------------
      for (int i = 0; i < 17; i++) begin
         vecs[i].wr_en     = 1'b1;
         vecs[i].data      = 8'h10 + 8'(i);
         vecs[i].exp_count = (i < DEPTH) ? i + 1 : DEPTH;
         vecs[i].exp_full  = (i >= DEPTH - 1);
         vecs[i].exp_empty = 1'b0;
         vecs[i].exp_ovf   = (i >= DEPTH);
      end
      vecs[17] = '{wr_en: 1'b0, data: 8'hEE, exp_count: DEPTH,
                   exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b1};
      reset_dut();
      tx_busy = 1'b1;
      for (int i = 0; i < 18; i++) begin
         wr_en   = vecs[i].wr_en;
         wr_data = vecs[i].data;
         cycle();
         check($sformatf("vec%0d_count", i),    count,    vecs[i].exp_count);
         check($sformatf("vec%0d_full", i),     full,     vecs[i].exp_full);
         check($sformatf("vec%0d_empty", i),    empty,    vecs[i].exp_empty);
         check($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
         check($sformatf("vec%0d_transmit", i), transmit, 0);
      end
      wr_en   = 1'b0;
      mode    = TX_FAST;
      tx_busy = 1'b0;
      repeat (250) cycle();
      check("fill_drain_pulses", tx_log.size(), DEPTH);
      for (int i = 0; i < DEPTH; i++)
         if (i < tx_log.size()) check($sformatf("fill_drain_byte%0d", i), tx_log[i], 8'h10 + 8'(i));
      check("fill_drain_empty", empty, 1);
      check("fill_overflow_sticky", overflow, 1);

      // ---------------- full + WAIT_DONE, release busy while writing ----------------
      reset_dut();
      for (int i = 0; i < 17; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h40 + 8'(i);
         cycle();
         if (i == 1) begin
            check("fw_first_launch", transmit, 1);
            check("fw_first_data", data_in, 8'h40);
         end
         if (i == 2) tx_busy = 1'b1;
      end
      check("fw_full_count", count, DEPTH);
      check("fw_full_flag", full, 1);
      check("fw_no_overflow_yet", overflow, 0);
      wr_data = 8'hEE;
      tx_busy = 1'b0;
      cycle();
      check("fw_release_count", count, DEPTH);
      check("fw_release_overflow", overflow, 1);
      check("fw_release_transmit", transmit, 0);
      cycle();
      wr_en = 1'b0;
      check("fw_pop_transmit", transmit, 1);
      check("fw_pop_count", count, DEPTH - 1);
      check("fw_pop_data", data_in, 8'h41);
      check("fw_pop_full", full, 0);
      check("fw_pop_overflow", overflow, 1);

      // ---------------- start timeout ----------------
      reset_dut();
      wr_data = 8'h5A;
      wr_en   = 1'b1;
      cycle();
      wr_en = 1'b0;
      cycle();
      check("to_launch", transmit, 1);
      for (int k = 1; k <= START_TIMEOUT; k++) begin
         cycle();
         check($sformatf("to_start_err_k%0d", k), start_err, k == START_TIMEOUT);
      end
      repeat (3) cycle();
      check("to_no_retry", tx_log.size(), 1);
      wr_data = 8'h77;
      wr_en   = 1'b1;
      cycle();
      wr_en = 1'b0;
      cycle();
      check("to_idle_relaunch", transmit, 1);
      check("to_idle_relaunch_data", data_in, 8'h77);
      check("to_start_err_sticky", start_err, 1);

      // ---------------- reset mid-frame ----------------
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h60 + 8'(i);
         cycle();
         if (i == 2) tx_busy = 1'b1;
      end
      wr_en = 1'b0;
      check("mid_count_before", count, 5);
      #200;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_async");
      @(posedge clk);
      #1;
      check("mid_held_count", count, 0);
      tx_busy = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tx_log.delete();
      prev_transmit = 0;
      cycle();
      check("mid_first_edge_transmit", transmit, 0);
      repeat (30) cycle();
      check("mid_no_relaunch", tx_log.size(), 0);
      check("mid_empty_after", empty, 1);

      // ---------------- 9600 baud loopback ----------------
      reset_dut();
      mode  = TX_SERIAL;
      wr_en = 1'b1;
      wr_data = 8'h3C; cycle();
      wr_data = 8'hFF; cycle();
      wr_data = 8'h00; cycle();
      wr_en = 1'b0;
      for (int n = 0; n < 5000 && rx_log.size() < 3; n++) cycle();
      repeat (20) cycle();
      check("lb_rx_count", rx_log.size(), 3);
      check("lb_pulses", tx_log.size(), 3);
      if (rx_log.size() >= 3) begin
         check("lb_rx0", rx_log[0], 8'h3C);
         check("lb_rx1", rx_log[1], 8'hFF);
         check("lb_rx2", rx_log[2], 8'h00);
      end
      for (int i = 0; i < pulse_falls.size(); i++)
         check($sformatf("lb_pulse%0d_after_fall", i), pulse_falls[i], i);

      // ---------------- randomized run against the reference model ----------------
      reset_dut();
      mode     = TX_FAST;
      model_on = 1;
      for (int seg = 0; seg < 3; seg++) begin
         for (int n = 0; n < 300; n++) begin
            wr_en   = ($urandom_range(0, 99) < (seg == 0 ? 30 : (seg == 1 ? 60 : 95)));
            wr_data = 8'($urandom);
            cycle();
         end
      end
      wr_en = 1'b0;
      repeat (250) cycle();
      check("rand_model_drained", model_q.size(), 0);
      check("rand_count_zero", count, 0);
      check("rand_start_err", start_err, 0);
      model_on = 0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule : tb_uart_tx_queue
